// File: rtl/sbox_sweep_char_pkg.sv
// Shared definitions for the S-box sweep characterisation harness:
// FSM state encoding and element/width constants.
package sbox_sweep_char_pkg;

    localparam int N_ELEM = 64;
    localparam int W      = 6;
    localparam int CHK_W  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sweep_align_pipe.sv
// Delay line carrying {valid, idx} alongside the attached S-box latency so each
// S-box output can be paired with the input that produced it. LAT = 0 is pure wiring.
module sweep_align_pipe
    import sbox_sweep_char_pkg::*;
#(
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue_valid,
    input  logic [W-1:0] issue_idx,
    output logic         cap_valid,
    output logic [W-1:0] cap_idx
);

    generate
        if (LAT == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign cap_valid      = issue_valid;
            assign cap_idx        = issue_idx;
        end else begin : g_pipe
            logic [W:0] stage [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= {issue_valid, issue_idx};
                    for (int i = 1; i < LAT; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign cap_valid = stage[LAT-1][W];
            assign cap_idx   = stage[LAT-1][W-1:0];
        end
    endgenerate

endmodule

// File: rtl/sbox_sweep_char.sv
// Sweeps x = 0..63 through an attached 6-bit S-box, collects every output and
// reports permutation status, fixed-point count, image of zero and a checksum.
module sbox_sweep_char
    import sbox_sweep_char_pkg::*;
#(
    parameter int LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [W-1:0]     sbox_x,
    input  logic [W-1:0]     sbox_y,
    output logic             busy,
    output logic             done,
    output logic             is_perm,
    output logic [W:0]       fixed_cnt,
    output logic [W-1:0]     zero_img,
    output logic [CHK_W-1:0] checksum
);

    state_t              state, state_next;
    logic                accept;
    logic [W-1:0]        idx;
    logic                issue_valid;
    logic                cap_valid;
    logic [W-1:0]        cap_idx;
    logic [N_ELEM-1:0]   bitmap;
    logic [N_ELEM-1:0]   y_onehot;
    logic                dup;
    logic                last_seen;

    assign issue_valid = (state == SWEEP);
    assign sbox_x      = issue_valid ? idx : '0;
    assign busy        = (state == SWEEP) || (state == DRAIN);
    assign done        = (state == DONE);
    assign y_onehot    = {{(N_ELEM-1){1'b0}}, 1'b1} << sbox_y;

    sweep_align_pipe #(
        .LAT (LAT)
    ) u_align (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_idx   (idx),
        .cap_valid   (cap_valid),
        .cap_idx     (cap_idx)
    );

    // start only counts in IDLE or DONE; DRAIN waits one edge past the final capture
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                if (idx == '1) state_next = DRAIN;
            end
            DRAIN: begin
                if (last_seen) state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SWEEP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (accept) begin
            idx <= '0;
        end else if (issue_valid) begin
            idx <= idx + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Result accumulation; is_perm is only published on the DRAIN -> DONE edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap    <= '0;
            dup       <= 1'b0;
            last_seen <= 1'b0;
            is_perm   <= 1'b0;
            fixed_cnt <= '0;
            zero_img  <= '0;
            checksum  <= '0;
        end else if (accept) begin
            bitmap    <= '0;
            dup       <= 1'b0;
            last_seen <= 1'b0;
            is_perm   <= 1'b0;
            fixed_cnt <= '0;
            zero_img  <= '0;
            checksum  <= '0;
        end else begin
            if (cap_valid) begin
                dup      <= dup | (|(bitmap & y_onehot));
                bitmap   <= bitmap | y_onehot;
                checksum <= checksum + {{(CHK_W-W){1'b0}}, sbox_y};
                if (sbox_y == cap_idx) fixed_cnt <= fixed_cnt + {{W{1'b0}}, 1'b1};
                if (cap_idx == '0)     zero_img  <= sbox_y;
                if (cap_idx == '1)     last_seen <= 1'b1;
            end
            if (state == DRAIN && last_seen) is_perm <= ~dup;
        end
    end

endmodule

// File: tb/tb_sbox_sweep_char.sv
// Self-checking bench: three harness instances (LAT = 0, 1, 2), each driving a
// bench-side S-box lookup table with the matching latency.
module tb_sbox_sweep_char;

    logic        clk;
    logic        rst;
    logic        start;

    logic [5:0]  sbox_x_s    [3];
    logic [5:0]  sbox_y_s    [3];
    logic        busy_s      [3];
    logic        done_s      [3];
    logic        is_perm_s   [3];
    logic [6:0]  fixed_s     [3];
    logic [5:0]  zero_s      [3];
    logic [11:0] checksum_s  [3];

    logic [5:0]  lut [3][64];
    int          cyc_done [3];

    int checks;
    int failures;

    typedef struct {
        string name;
        int    lat;
        int    kind;
        int    exp_perm;
        int    exp_fixed;
        int    exp_zero;
        int    exp_sum;
    } vec_t;

    vec_t vecs [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        logic [5:0] y_d1;
        logic [5:0] y_d2;

        sbox_sweep_char #(
            .LAT (g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .sbox_x    (sbox_x_s[g]),
            .sbox_y    (sbox_y_s[g]),
            .busy      (busy_s[g]),
            .done      (done_s[g]),
            .is_perm   (is_perm_s[g]),
            .fixed_cnt (fixed_s[g]),
            .zero_img  (zero_s[g]),
            .checksum  (checksum_s[g])
        );

        always @(posedge clk) begin
            y_d1 <= lut[g][sbox_x_s[g]];
            y_d2 <= y_d1;
        end

        assign sbox_y_s[g] = (g == 0) ? lut[g][sbox_x_s[g]] : ((g == 1) ? y_d1 : y_d2);
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] aa;
        logic [5:0] p;
        p  = '0;
        aa = {1'b0, a};
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ aa[5:0];
            aa = aa << 1;
            if (aa[6]) aa = aa ^ 7'h43;
        end
        return p;
    endfunction

    function automatic logic [5:0] gf_pow(input logic [5:0] x, input int e);
        logic [5:0] r;
        r = 6'd1;
        for (int i = 0; i < e; i++) r = gf_mul(r, x);
        return r;
    endfunction

    // kinds: 0 identity, 1 x^20, 2 const 5, 3 x xor 3F, 4 random permutation, 5 random map
    task automatic load_lut(input int lat, input int kind);
        logic [5:0] tmp;
        int         j;
        for (int x = 0; x < 64; x++) begin
            case (kind)
                0:       lut[lat][x] = 6'(x);
                1:       lut[lat][x] = gf_pow(6'(x), 20);
                2:       lut[lat][x] = 6'd5;
                3:       lut[lat][x] = 6'(x) ^ 6'h3F;
                4:       lut[lat][x] = 6'(x);
                default: lut[lat][x] = 6'($urandom_range(0, 63));
            endcase
        end
        if (kind == 4) begin
            for (int i = 63; i > 0; i--) begin
                j              = $urandom_range(0, i);
                tmp            = lut[lat][i];
                lut[lat][i]    = lut[lat][j];
                lut[lat][j]    = tmp;
            end
        end
    endtask

    task automatic ref_model(input int lat, output int perm, output int fixed,
                             output int zero, output int sum);
        bit seen [64];
        int y;
        perm  = 1;
        fixed = 0;
        sum   = 0;
        zero  = int'(lut[lat][0]);
        for (int x = 0; x < 64; x++) seen[x] = 1'b0;
        for (int x = 0; x < 64; x++) begin
            y = int'(lut[lat][x]);
            if (seen[y]) perm = 0;
            seen[y] = 1'b1;
            if (y == x) fixed++;
            sum += y;
        end
        sum = sum % 4096;
    endtask

    // One sweep on all three instances; hold = number of edges start stays high after acceptance
    task automatic applyStimulus(input int hold);
        int cyc;
        int bad_issue;
        int overlap;
        int exp_x;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (hold == 0) start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc_done[i] = -1;
            check($sformatf("lat%0d_accept_flags", i), int'({done_s[i], busy_s[i]}), 1);
            check($sformatf("lat%0d_accept_clear", i),
                  int'({is_perm_s[i], fixed_s[i], zero_s[i], checksum_s[i]}), 0);
        end
        cyc       = 0;
        bad_issue = 0;
        overlap   = 0;
        for (int i = 0; i < 3; i++) if (sbox_x_s[i] != 6'd0) bad_issue++;
        while ((cyc_done[0] < 0 || cyc_done[1] < 0 || cyc_done[2] < 0) && cyc < 150) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == hold) start = 1'b0;
            exp_x = (cyc <= 63) ? cyc : 0;
            for (int i = 0; i < 3; i++) begin
                if (done_s[i] && cyc_done[i] < 0) cyc_done[i] = cyc;
                if (int'(sbox_x_s[i]) != exp_x) bad_issue++;
                if (busy_s[i] && done_s[i]) overlap++;
            end
        end
        start = 1'b0;
        check("issue_sequence_errors", bad_issue, 0);
        check("busy_done_overlap", overlap, 0);
    endtask

    task automatic checkOutput(input string tag, input int lat, input int use_const,
                               input int c_perm, input int c_fixed, input int c_zero,
                               input int c_sum);
        int m_perm, m_fixed, m_zero, m_sum;
        if (use_const != 0) begin
            m_perm  = c_perm;
            m_fixed = c_fixed;
            m_zero  = c_zero;
            m_sum   = c_sum;
        end else begin
            ref_model(lat, m_perm, m_fixed, m_zero, m_sum);
        end
        check($sformatf("%s_lat%0d_cycles", tag, lat), cyc_done[lat], 65 + lat);
        check($sformatf("%s_lat%0d_is_perm", tag, lat), int'(is_perm_s[lat]), m_perm);
        check($sformatf("%s_lat%0d_fixed", tag, lat), int'(fixed_s[lat]), m_fixed);
        check($sformatf("%s_lat%0d_zero_img", tag, lat), int'(zero_s[lat]), m_zero);
        check($sformatf("%s_lat%0d_checksum", tag, lat), int'(checksum_s[lat]), m_sum);
    endtask

    task automatic run_vector(input vec_t v);
        for (int i = 0; i < 3; i++) if (i != v.lat) load_lut(i, 4);
        load_lut(v.lat, v.kind);
        applyStimulus(0);
        for (int i = 0; i < 3; i++) begin
            if (i == v.lat)
                checkOutput(v.name, i, 1, v.exp_perm, v.exp_fixed, v.exp_zero, v.exp_sum);
            else
                checkOutput({v.name, "_side"}, i, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_lat%0d_outputs", tag, i),
                  int'({busy_s[i], done_s[i], is_perm_s[i], fixed_s[i], zero_s[i],
                        checksum_s[i], sbox_x_s[i]}), 0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        rst      = 1'b0;
        for (int i = 0; i < 3; i++) load_lut(i, 0);

        vecs[0] = '{name: "identity", lat: 0, kind: 0, exp_perm: 1, exp_fixed: 64, exp_zero: 0,  exp_sum: 2016};
        vecs[1] = '{name: "pow20",    lat: 0, kind: 1, exp_perm: 1, exp_fixed: 2,  exp_zero: 0,  exp_sum: 2016};
        vecs[2] = '{name: "const5",   lat: 2, kind: 2, exp_perm: 0, exp_fixed: 1,  exp_zero: 5,  exp_sum: 320};
        vecs[3] = '{name: "xor3f",    lat: 1, kind: 3, exp_perm: 1, exp_fixed: 0,  exp_zero: 63, exp_sum: 2016};

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) run_vector(vecs[v]);

        // Reset in the middle of a sweep must clear everything immediately
        load_lut(0, 3);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        check("midsweep_busy_before_reset", int'(busy_s[0]), 1);
        rst = 1'b1;
        #1;
        check_all_zero("midsweep_reset");
        @(negedge clk);
        rst = 1'b0;
        run_vector(vecs[0]);

        // start held high across the whole sweep gives exactly one sweep
        load_lut(0, 0);
        load_lut(1, 4);
        load_lut(2, 5);
        applyStimulus(64);
        checkOutput("held_start", 0, 1, 1, 64, 0, 2016);
        checkOutput("held_start", 1, 0, 0, 0, 0, 0);
        checkOutput("held_start", 2, 0, 0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        check("done_sticky", int'({done_s[0], busy_s[0]}), 2);

        // A fresh start in DONE clears and recomputes
        load_lut(0, 2);
        applyStimulus(0);
        checkOutput("restart_const5", 0, 1, 0, 1, 5, 320);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 3; i++) load_lut(i, $urandom_range(4, 5));
            applyStimulus(0);
            for (int i = 0; i < 3; i++) checkOutput($sformatf("random%0d", r), i, 0, 0, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
